// File: rtl/uart_pkg.sv
// Shared UART types, widths and baud helper; UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int WIDTH = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic int calc_period(input int baud_rate, input int freq_sys);
    return freq_sys / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..PERIOD-1 while enabled, strobes o_bit_end on the last count.
// Holds its value when i_en is low; i_sync_clr forces zero on the next edge.
module uart_baud_counter #(
  parameter int PERIOD = 13020,
  parameter int CW     = 14
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_sync_clr,
  output logic o_bit_end
);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last    = (r_cnt == CW'(PERIOD - 1));
  assign o_bit_end = i_en && w_last && !i_sync_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_sync_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined); tx goes low the cycle after start is accepted.
// Requests are taken only while idle, never queued; en low freezes the frame in place.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int baudRate = 9600,
  parameter int freq_Sys = 125000000
) (
  input  logic             clkSys,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] byte_dat,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int period = calc_period(baudRate, freq_Sys);
  localparam int CW     = (period > 1) ? $clog2(period) : 1;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [2:0]       r_index, w_index_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_bit_end;
  logic             w_sync_clr;
`ifdef UART_TX_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  // Counter is parked at zero while idle so every frame starts on a full bit.
  assign w_sync_clr = (r_state == IDLE);

  uart_baud_counter #(
    .PERIOD(period),
    .CW    (CW)
  ) u_baud (
    .i_clk     (clkSys),
    .i_rst_n   (rst),
    .i_en      (en),
    .i_sync_clr(w_sync_clr),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_index <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_index <= w_index_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_index_nxt = r_index;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (en && start) begin
          w_state_nxt = START;
          w_shift_nxt = byte_dat;
          w_index_nxt = '0;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = ^byte_dat;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          w_index_nxt = r_index + 1'b1;
          if (r_index == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_tx_nxt = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
